// File: rtl/fifo_write_arbiter_pkg.sv
// fifo_arb_pkg: shared types, defaults and wrap helper for the FIFO write arbiter
package fifo_arb_pkg;
  typedef enum logic {IDLE, BURST} arb_state_t;
  localparam int NREQ_DEF = 4;
  localparam int MAXBURST_DEF = 4;
  // a + b modulo n, valid when both operands are already below n
  function automatic int wrap_add(int a, int b, int n);
    int s;
    s = a + b;
    return s >= n ? s - n : s;
  endfunction
endpackage

// File: rtl/fifo_write_arbiter_if.sv
// fifo_write_arbiter_if: requester lanes plus FIFO write port, seen from the arbiter (master) and the environment (slave)
interface fifo_write_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int DATA = 8,
  parameter int IDW  = $clog2(NREQ)
);
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      last;
  logic [NREQ*DATA-1:0] wdata_in;
  logic [NREQ-1:0]      ack;
  logic                 fifo_full;
  logic                 fifo_w_en;
  logic [DATA-1:0]      fifo_wdata;
  logic [IDW-1:0]       owner;
  logic                 busy;
  modport master (
    input  req, last, wdata_in, fifo_full,
    output ack, fifo_w_en, fifo_wdata, owner, busy
  );
  modport slave (
    output req, last, wdata_in, fifo_full,
    input  ack, fifo_w_en, fifo_wdata, owner, busy
  );
endinterface

// File: rtl/fifo_write_arbiter_rr_picker.sv
// rr_picker: first set request searching upward from a rotating pointer, wrapping modulo NREQ
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [IDW-1:0]  o_idx,
  output logic            o_found
);
  logic [IDW-1:0] w_idx;
  // scan from the farthest offset down so the nearest set bit wins
  always_comb begin
    o_found = 1'b0;
    o_idx = '0;
    w_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = IDW'(wrap_add(int'(i_ptr), k, NREQ));
      if (i_req[w_idx]) begin
        o_found = 1'b1;
        o_idx = w_idx;
      end
    end
  end
endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin burst arbiter sharing one FIFO write port among NREQ requesters
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ     = NREQ_DEF,
  parameter int DATA     = 8,
  parameter int MAXBURST = MAXBURST_DEF,
  parameter int IDW      = $clog2(NREQ)
) (
  input logic                 wclk,
  input logic                 wrst,
  fifo_write_arbiter_if.master bus
);
  localparam int BW = $clog2(MAXBURST + 1);
  arb_state_t     r_state;
  logic [IDW-1:0] r_owner;
  logic [IDW-1:0] r_rr_ptr;
  logic [BW-1:0]  r_beat;
  logic [IDW-1:0] w_winner;
  logic           w_found;
  logic           w_busy;
  logic           w_sel;
  logic           w_en;
  logic           w_exit;
  rr_picker #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .i_req  (bus.req),
    .i_ptr  (r_rr_ptr),
    .o_idx  (w_winner),
    .o_found(w_found)
  );
  assign w_busy = r_state == BURST;
  assign w_sel  = bus.req[r_owner];
  assign w_en   = w_busy & w_sel & ~bus.fifo_full;
  // a withdrawn request ends the grant without a transfer; full never does
  assign w_exit = w_busy & (~w_sel | (w_en & (bus.last[r_owner] | r_beat == BW'(MAXBURST - 1))));
  assign bus.busy       = w_busy;
  assign bus.owner      = r_owner;
  assign bus.fifo_w_en  = w_en;
  assign bus.ack        = w_en ? NREQ'(1) << r_owner : '0;
  assign bus.fifo_wdata = bus.wdata_in[r_owner*DATA +: DATA];
  always_ff @(posedge wclk or negedge wrst)
    if (!wrst) begin
      r_state  <= IDLE;
      r_owner  <= '0;
      r_rr_ptr <= '0;
      r_beat   <= '0;
    end else if (r_state == IDLE) begin
      if (w_found) begin
        r_state <= BURST;
        r_owner <= w_winner;
        r_beat  <= '0;
      end
    end else if (w_exit) begin
      r_state  <= IDLE;
      r_rr_ptr <= r_owner == IDW'(NREQ - 1) ? '0 : r_owner + 1'b1;
    end else if (w_en)
      r_beat <= r_beat + 1'b1;
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: directed per-cycle vectors for the write arbiter (NREQ=4, DATA=8, MAXBURST=4)
module tb_fifo_write_arbiter;
  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] last;
    logic       full;
    logic       busy;
    logic [1:0] owner;
    logic [3:0] ack;
    logic       wen;
    logic [7:0] data;
  } vec_t;

  logic       clk = 1'b0;
  logic       wrst = 1'b0;
  logic [7:0] lane [4];
  int         compared = 0;
  int         mismatched = 0;
  vec_t       tbl [$];

  fifo_write_arbiter_if #(.NREQ(4), .DATA(8)) bus ();
  fifo_write_arbiter #(.NREQ(4), .DATA(8), .MAXBURST(4)) dut (.wclk(clk), .wrst(wrst), .bus(bus));

  always #5 clk = ~clk;
  always_comb for (int i = 0; i < 4; i++) bus.wdata_in[i*8 +: 8] = lane[i];

  function automatic vec_t mk(logic rst, logic [3:0] req, logic [3:0] last, logic full,
                              logic busy, logic [1:0] owner, logic wen, logic [7:0] data);
    vec_t v;
    v.rst = rst; v.req = req; v.last = last; v.full = full;
    v.busy = busy; v.owner = owner; v.wen = wen; v.data = data;
    v.ack = wen ? 4'b0001 << owner : 4'b0000;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // inputs change on the falling edge; requesters advance their lane only on a sampled ack
  task automatic step(input vec_t v);
    logic [3:0] a;
    @(negedge clk);
    wrst = v.rst; bus.req = v.req; bus.last = v.last; bus.fifo_full = v.full;
    #1;
    chk("busy", int'(bus.busy), int'(v.busy));
    chk("ack", int'(bus.ack), int'(v.ack));
    chk("fifo_w_en", int'(bus.fifo_w_en), int'(v.wen));
    if (v.busy || !v.rst) chk("owner", int'(bus.owner), int'(v.owner));
    if (v.wen) chk("fifo_wdata", int'(bus.fifo_wdata), int'(v.data));
    a = bus.ack;
    @(posedge clk);
    for (int i = 0; i < 4; i++) if (a[i]) lane[i] = lane[i] + 8'd1;
  endtask

  initial begin
    int   o [5];
    logic [7:0] b [5];
    o = '{0, 1, 2, 3, 0};
    b = '{8'h00, 8'h50, 8'h18, 8'h30, 8'h04};
    lane[0] = 8'h00; lane[1] = 8'h50; lane[2] = 8'h10; lane[3] = 8'h30;
    bus.req = '0; bus.last = '0; bus.fifo_full = 1'b0;
    // idle with no requests
    for (int k = 0; k < 10; k++) tbl.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 0, 8'h00));
    // single requester: two 4-word bursts separated by one arbitration bubble
    tbl.push_back(mk(1, 4'b0100, 0, 0, 0, 0, 0, 8'h00));
    for (int k = 0; k < 4; k++) tbl.push_back(mk(1, 4'b0100, 0, 0, 1, 2, 1, 8'(16 + k)));
    tbl.push_back(mk(1, 4'b0100, 0, 0, 0, 0, 0, 8'h00));
    for (int k = 0; k < 4; k++) tbl.push_back(mk(1, 4'b0100, 0, 0, 1, 2, 1, 8'(20 + k)));
    tbl.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 0, 8'h00));
    // reset pointer, then all four requesting: owners 0,1,2,3,0
    tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 0, 8'h00));
    for (int j = 0; j < 5; j++) begin
      tbl.push_back(mk(1, 4'b1111, 0, 0, 0, 0, 0, 8'h00));
      for (int k = 0; k < 4; k++) tbl.push_back(mk(1, 4'b1111, 0, 0, 1, 2'(o[j]), 1, 8'(int'(b[j]) + k)));
    end
    tbl.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 0, 8'h00));

    repeat (2) @(posedge clk);
    foreach (tbl[i]) step(tbl[i]);

    // last on requester 1's second word ends the burst; pointer moves past it to 0
    lane[1] = 8'hA0;
    step(mk(1, 4'b0011, 4'b0000, 0, 0, 0, 0, 8'h00));
    step(mk(1, 4'b0011, 4'b0000, 0, 1, 1, 1, 8'hA0));
    step(mk(1, 4'b0011, 4'b0010, 0, 1, 1, 1, 8'hA1));
    step(mk(1, 4'b0011, 4'b0000, 0, 0, 0, 0, 8'h00));
    // full stalls the grant for 5 cycles after the 2nd ack, then exactly 2 more acks
    step(mk(1, 4'b0011, 0, 0, 1, 0, 1, 8'h08));
    step(mk(1, 4'b0011, 0, 0, 1, 0, 1, 8'h09));
    repeat (5) step(mk(1, 4'b0011, 0, 1, 1, 0, 0, 8'h00));
    step(mk(1, 4'b0011, 0, 0, 1, 0, 1, 8'h0A));
    step(mk(1, 4'b0011, 0, 0, 1, 0, 1, 8'h0B));
    step(mk(1, 4'b0000, 0, 0, 0, 0, 0, 8'h00));
    // async reset after the 1st ack of a burst, then pointer restarts at 0
    step(mk(1, 4'b0100, 0, 0, 0, 0, 0, 8'h00));
    step(mk(1, 4'b0100, 0, 0, 1, 2, 1, 8'h1C));
    step(mk(0, 4'b0100, 0, 0, 0, 0, 0, 8'h00));
    step(mk(0, 4'b0100, 0, 0, 0, 0, 0, 8'h00));
    step(mk(1, 4'b0101, 0, 0, 0, 0, 0, 8'h00));
    step(mk(1, 4'b0101, 0, 0, 1, 0, 1, 8'h0C));
    // withdrawal ends the burst without an ack
    step(mk(1, 4'b0000, 0, 0, 1, 0, 0, 8'h00));
    step(mk(1, 4'b0000, 0, 0, 0, 0, 0, 8'h00));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
